dds_sweep_ctrl: RTL and testbench

//  Frequency-sweep controller for the DDS chain; sits directly upstream of the phase accumulator.
//  - Drives the accumulator's 8-bit phinc (phase increment) input.
//  - Steps phinc linearly from f_start to f_stop and holds each value for a programmable dwell.
//  - Sweep modes: single up-sweep, or continuous triangle (up/down).

---
 rtl/dds_sweep_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency-sweep controller feeding the DDS phase accumulator.
// Steps phinc from f_start to f_stop with a programmable dwell, as a single
// up-sweep or a continuous triangle.
// Optional build macro SWEEP_MUTE_EN: forces phinc to 0 whenever the controller is idle.
module dds_sweep_ctrl #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         f_start,
  input  logic [7:0]         f_stop,
  input  logic [7:0]         step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [7:0]         phinc,
  output logic               busy,
  output logic               dir,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t             state, state_n;
  logic [7:0]         phinc_n;
  logic               busy_n, dir_n, done_n;
  logic [DWELL_W-1:0] cnt, cnt_n;

  // configuration captured on the accepted start
  logic [7:0]         cfg_start, cfg_start_n;
  logic [7:0]         cfg_stop, cfg_stop_n;
  logic [7:0]         cfg_step, cfg_step_n;
  logic [DWELL_W-1:0] cfg_dm1, cfg_dm1_n;
  logic               cfg_mode, cfg_mode_n;

  // derived values for the next step in either direction
  logic [7:0]         in_step;
  logic [DWELL_W-1:0] in_dm1;
  logic [8:0]         sum, diff;
  logic [7:0]         up_val, dn_val;
  logic               expired, at_top, at_bot, degen;

  assign in_step = (step == 8'd0) ? 8'd1 : step;
  assign in_dm1  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign sum     = {1'b0, phinc} + {1'b0, cfg_step};
  assign diff    = {1'b0, phinc} - {1'b0, cfg_step};
  assign up_val  = (sum[8] || (sum[7:0] >= cfg_stop)) ? cfg_stop : sum[7:0];
  assign dn_val  = (diff[8] || (diff[7:0] <= cfg_start)) ? cfg_start : diff[7:0];
  assign expired = (cnt == '0);
  // at_top uses >= so an empty range (f_stop <= f_start) counts as already at the top
  assign at_top  = (phinc >= cfg_stop);
  assign at_bot  = (phinc <= cfg_start);
  assign degen   = (cfg_stop <= cfg_start);

  // state, output and configuration registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      phinc     <= '0;
      busy      <= 1'b0;
      dir       <= 1'b1;
      done      <= 1'b0;
      cnt       <= '0;
      cfg_start <= '0;
      cfg_stop  <= '0;
      cfg_step  <= 8'd1;
      cfg_dm1   <= '0;
      cfg_mode  <= 1'b0;
    end else begin
      state     <= state_n;
      phinc     <= phinc_n;
      busy      <= busy_n;
      dir       <= dir_n;
      done      <= done_n;
      cnt       <= cnt_n;
      cfg_start <= cfg_start_n;
      cfg_stop  <= cfg_stop_n;
      cfg_step  <= cfg_step_n;
      cfg_dm1   <= cfg_dm1_n;
      cfg_mode  <= cfg_mode_n;
    end
  end

  // next-state logic: dwell countdown, stepping with clamps, turnarounds and abort
  always_comb begin
    state_n     = state;
    phinc_n     = phinc;
    busy_n      = busy;
    dir_n       = dir;
    done_n      = 1'b0;
    cnt_n       = cnt;
    cfg_start_n = cfg_start;
    cfg_stop_n  = cfg_stop;
    cfg_step_n  = cfg_step;
    cfg_dm1_n   = cfg_dm1;
    cfg_mode_n  = cfg_mode;

    if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      dir_n   = 1'b1;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_start_n = f_start;
            cfg_stop_n  = f_stop;
            cfg_step_n  = in_step;
            cfg_dm1_n   = in_dm1;
            cfg_mode_n  = mode;
            phinc_n     = f_start;
            cnt_n       = in_dm1;
            busy_n      = 1'b1;
            dir_n       = 1'b1;
            state_n     = UP;
          end
        end
        UP: begin
          if (expired) begin
            cnt_n = cfg_dm1;
            if (at_top) begin
              if (!cfg_mode) begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                dir_n   = 1'b1;
                state_n = IDLE;
              end else if (!degen) begin
                // turn around on this edge so the top value is not dwelt twice
                dir_n   = 1'b0;
                state_n = DOWN;
                phinc_n = dn_val;
              end
            end else begin
              phinc_n = up_val;
            end
          end else begin
            cnt_n = cnt - DWELL_W'(1);
          end
        end
        DOWN: begin
          if (expired) begin
            cnt_n = cfg_dm1;
            if (at_bot) begin
              dir_n   = 1'b1;
              state_n = UP;
              phinc_n = up_val;
            end else begin
              phinc_n = dn_val;
            end
          end else begin
            cnt_n = cnt - DWELL_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          busy_n  = 1'b0;
          dir_n   = 1'b1;
        end
      endcase
    end

`ifdef SWEEP_MUTE_EN
    if (state_n == IDLE) phinc_n = '0;
`endif
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: table of sweep configurations with hand-derived
// phinc level sequences, expanded into a per-cycle expectation queue.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  f_start = '0;
  logic [7:0]  f_stop = '0;
  logic [7:0]  step = '0;
  logic [15:0] dwell = '0;
  logic [7:0]  phinc;
  logic        busy, dir, done;

  int unsigned total = 0;
  int unsigned bad = 0;

  dds_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk(clk), .clrn(clrn), .start(start), .stop(stop), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .step(step), .dwell(dwell),
    .phinc(phinc), .busy(busy), .dir(dir), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      fs, fe, st;
    logic [15:0]     dw;
    logic            md;
    int              rep;   // cycles each level is held
    int              nl;    // number of levels
    logic [0:7][7:0] lv;    // phinc levels in order
    logic [0:7]      dl;    // dir per level
    int              poke;  // sequence index after which a stray start is pulsed, -1 none
  } vec_t;

  typedef struct {
    logic [7:0] ph;
    logic       busy, dir, done;
  } exp_t;

  vec_t vecs[6];
  exp_t q[$];
  logic [7:0] last_ph;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input exp_t e);
    chk({tag, " phinc"}, 32'(phinc), 32'(e.ph));
    chk({tag, " busy"},  32'(busy),  32'(e.busy));
    chk({tag, " dir"},   32'(dir),   32'(e.dir));
    chk({tag, " done"},  32'(done),  32'(e.done));
  endtask

  function automatic logic [7:0] idle_val(input logic [7:0] held);
`ifdef SWEEP_MUTE_EN
    return 8'd0;
`else
    return held;
`endif
  endfunction

  task automatic run_vec(input int vi);
    vec_t v;
    exp_t e;
    int   nseq, idx;
    v    = vecs[vi];
    nseq = v.nl * v.rep;
    for (int l = 0; l < v.nl; l++)
      for (int r = 0; r < v.rep; r++)
        q.push_back('{ph: v.lv[l], busy: 1'b1, dir: v.dl[l], done: 1'b0});
    last_ph = idle_val(v.lv[v.nl-1]);
    q.push_back('{ph: last_ph, busy: 1'b0, dir: 1'b1, done: !v.md});
    q.push_back('{ph: last_ph, busy: 1'b0, dir: 1'b1, done: 1'b0});

    f_start = v.fs; f_stop = v.fe; step = v.st; dwell = v.dw; mode = v.md;
    start = 1'b1;
    cyc();
    start = 1'b0;
    idx = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk_outs($sformatf("v%0d.%0d", vi, idx), e);
      start = (idx == v.poke);
      if (idx == v.poke) begin
        f_start = 8'd100; f_stop = 8'd200; step = 8'd50; dwell = 16'd7; mode = 1'b0;
      end
      stop = v.md && (idx == nseq - 1);
      idx++;
      if (q.size() > 0) cyc();
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    //          fs     fe     st    dw     md rep nl  levels                                                     dirs          poke
    vecs[0] = '{8'd10,  8'd20,  8'd5, 16'd3, 1'b0, 3, 3, {8'd10,8'd15,8'd20,8'd0,8'd0,8'd0,8'd0,8'd0},     8'b11100000, -1};
    vecs[1] = '{8'd250, 8'd255, 8'd4, 16'd1, 1'b0, 1, 3, {8'd250,8'd254,8'd255,8'd0,8'd0,8'd0,8'd0,8'd0},  8'b11100000, -1};
    vecs[2] = '{8'd3,   8'd5,   8'd0, 16'd0, 1'b0, 1, 3, {8'd3,8'd4,8'd5,8'd0,8'd0,8'd0,8'd0,8'd0},        8'b11100000, -1};
    vecs[3] = '{8'd7,   8'd2,   8'd5, 16'd2, 1'b0, 2, 1, {8'd7,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0},        8'b10000000, -1};
    vecs[4] = '{8'd10,  8'd20,  8'd5, 16'd2, 1'b1, 2, 6, {8'd10,8'd15,8'd20,8'd15,8'd10,8'd15,8'd0,8'd0},  8'b11100100, 2};
    vecs[5] = '{8'd7,   8'd2,   8'd1, 16'd1, 1'b1, 1, 4, {8'd7,8'd7,8'd7,8'd7,8'd0,8'd0,8'd0,8'd0},        8'b11110000, -1};

    // reset state
    cyc();
    cyc();
    chk_outs("reset", '{ph: 8'd0, busy: 1'b0, dir: 1'b1, done: 1'b0});
    @(negedge clk);
    clrn = 1'b1;
    cyc();

    for (int i = 0; i < 6; i++) run_vec(i);

    // start and stop together in IDLE: stop wins
    f_start = 8'd99; f_stop = 8'd120; step = 8'd1; dwell = 16'd1; mode = 1'b0;
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk_outs("startstop", '{ph: last_ph, busy: 1'b0, dir: 1'b1, done: 1'b0});
    cyc();
    chk_outs("startstop+1", '{ph: last_ph, busy: 1'b0, dir: 1'b1, done: 1'b0});

    // asynchronous reset mid-sweep, then an exact replay of the first sweep
    f_start = 8'd10; f_stop = 8'd20; step = 8'd5; dwell = 16'd3; mode = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    chk("midsweep phinc", 32'(phinc), 32'd15);
    @(negedge clk);
    #1 clrn = 1'b0;
    #1;
    chk_outs("async reset", '{ph: 8'd0, busy: 1'b0, dir: 1'b1, done: 1'b0});
    cyc();
    @(negedge clk);
    clrn = 1'b1;
    cyc();
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
